crc16b: RTL and testbench



---
 rtl/crc_pkg.sv | 19 +
 rtl/crc16_byte_step.sv | 22 ++
 rtl/crc16b.sv | 41 ++++
 tb/tb_crc16b.sv | 129 ++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-16 constants and bit-reversal helpers
package crc_pkg;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// rtl/crc16_byte_step.sv - combinational fold of one MSB-first byte into a CRC-16
module crc16_byte_step
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_CCITT_POLY
) (
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_next
);

  logic [15:0] w_c;

  always_comb begin
    w_c = crc_in ^ {byte_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[15] ? ((w_c << 1) ^ POLY) : (w_c << 1);
    end
    crc_next = w_c;
  end

endmodule

// File: rtl/crc16b.sv
// rtl/crc16b.sv - byte-serial CRC-16 generator/checker, one byte per enabled clock
module crc16b
  import crc_pkg::*;
#(
  parameter logic [15:0] POLY   = CRC16_CCITT_POLY,
  parameter logic [15:0] INIT   = CRC16_CCITT_INIT,
  parameter bit          REFIN  = 1'b0,
  parameter bit          REFOUT = 1'b0,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] r_crc;
  logic [7:0]  w_d;
  logic [15:0] w_next;

  assign w_d = REFIN ? rev8(data_in) : data_in;

  crc16_byte_step #(.POLY(POLY)) u_step (
    .crc_in   (r_crc),
    .byte_in  (w_d),
    .crc_next (w_next)
  );

  // data_in is only consumed under crc_en, so X on idle cycles never reaches r_crc
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_crc <= INIT;
    end else if (crc_en) begin
      r_crc <= w_next;
    end
  end

  assign crc_out = (REFOUT ? rev16(r_crc) : r_crc) ^ XOROUT;

endmodule

// File: tb/tb_crc16b.sv
// tb/tb_crc16b.sv - self-checking bench for crc16b against a bit-serial division model
module tb_crc16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        crc_en;
  logic [7:0]  data_in;
  logic [15:0] crc_out;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] m_crc;

  logic [7:0] chk_str [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc16b dut (
    .clk     (clk),
    .rst     (rst),
    .crc_en  (crc_en),
    .data_in (data_in),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  // Long division of the message bit stream by x^16 + 0x1021, one bit at a time
  function automatic logic [15:0] model_fold(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[15] ^ b[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic en);
    rst = 1'b0; crc_en = en; data_in = 8'h5A;
    @(posedge clk); #1;
    rst = 1'b1; crc_en = 1'b0; data_in = 'x;
    m_crc = 16'hFFFF;
  endtask

  task automatic feed(input logic [7:0] b);
    crc_en = 1'b1; data_in = b;
    @(posedge clk); #1;
    crc_en = 1'b0; data_in = 'x;
    m_crc = model_fold(m_crc, b);
  endtask

  task automatic idle(input int n);
    crc_en = 1'b0; data_in = 'x;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed_chk(input bit gaps);
    for (int i = 0; i < 9; i++) begin
      feed(chk_str[i]);
      if (gaps && (i == 3 || i == 6)) idle(i - 1);
    end
  endtask

  initial begin
    rst = 1'b1; crc_en = 1'b0; data_in = 8'h00;
    m_crc = 16'hFFFF;
    @(posedge clk); #1;

    do_reset(1'b0);
    check("reset", crc_out, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("hold_after_reset", crc_out, 16'hFFFF);
    end

    feed(8'hAA);
    check("single_aa", crc_out, 16'hF550);
    feed(8'h36);
    check("second_36", crc_out, 16'hB92F);

    do_reset(1'b0);
    feed_chk(1'b0);
    check("check_string", crc_out, 16'h29B1);

    do_reset(1'b0);
    feed_chk(1'b1);
    check("check_string_gaps", crc_out, 16'h29B1);
    feed(8'h29);
    feed(8'hB1);
    check("residue", crc_out, 16'h0000);

    do_reset(1'b0);
    for (int i = 0; i < 4; i++) feed(chk_str[i]);
    do_reset(1'b1);
    check("reset_mid_msg", crc_out, 16'hFFFF);
    feed_chk(1'b0);
    check("check_after_reset", crc_out, 16'h29B1);

    for (int t = 0; t < 20; t++) begin
      int len;
      logic [15:0] fcs;
      do_reset(1'b0);
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        feed(8'($urandom));
        check("rand_byte", crc_out, m_crc);
        if ($urandom_range(0, 3) == 0) begin
          idle($urandom_range(1, 3));
          check("rand_gap_hold", crc_out, m_crc);
        end
      end
      fcs = m_crc;
      feed(fcs[15:8]);
      feed(fcs[7:0]);
      check("rand_residue", crc_out, 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
